// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic pipeline register for the CPU stage boundaries
// (ID/EX, EX/MEM, MEM/WB).
//
// The payload has two parts. Control bits are forced to zero whenever no valid
// entry is presented, so a bubble can never enable a write or a branch. Data
// bits are never masked and simply hold their last value.
//
// Handshake semantics: an entry moves when valid and ready are both high on a
// rising clock edge. accept = in_valid & in_ready, emit = out_valid & out_ready.
// in_valid and out_ready may change freely between edges.
//
// SKID = 1: main entry plus a skid entry. in_ready comes only from registers
//           (and rst), so there is no combinational path from out_ready.
// SKID = 0: main entry only. in_ready = ~main_valid | out_ready.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   flush           synchronous kill of every held entry (data regs kept)
//   in_valid/ready  upstream handshake
//   in_data/ctrl    upstream payload
//   out_valid/ready downstream handshake
//   out_data/ctrl   presented payload (ctrl is 0 while out_valid = 0)
//   count           number of held entries, 0..2
module pipe_stage_reg #(
    parameter int DATA_W = 133,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        count
);

    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic              skid_valid;
    logic              accept;
    logic              emit;

    assign accept = in_valid & in_ready;
    assign emit   = main_valid & out_ready;

    generate
        if (SKID != 0) begin : g_skid
            logic              skid_q;
            logic [DATA_W-1:0] skid_data;
            logic [CTRL_W-1:0] skid_ctrl;

            // Ready only depends on the skid register, so upstream timing
            // never sees the downstream ready path.
            assign in_ready   = ~rst & ~skid_q;
            assign skid_valid = skid_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    main_valid <= 1'b0;
                    main_data  <= '0;
                    main_ctrl  <= '0;
                    skid_q     <= 1'b0;
                    skid_data  <= '0;
                    skid_ctrl  <= '0;
                end else if (flush) begin
                    main_valid <= 1'b0;
                    skid_q     <= 1'b0;
                end else if (!main_valid || emit) begin
                    // Main slot is free this edge: refill from skid first to
                    // keep FIFO order. accept cannot be high while skid is full.
                    if (skid_q) begin
                        main_data  <= skid_data;
                        main_ctrl  <= skid_ctrl;
                        main_valid <= 1'b1;
                        skid_q     <= 1'b0;
                    end else if (accept) begin
                        main_data  <= in_data;
                        main_ctrl  <= in_ctrl;
                        main_valid <= 1'b1;
                    end else begin
                        main_valid <= 1'b0;
                    end
                end else if (accept) begin
                    // Main is stalled: park the new entry in the skid slot.
                    skid_data <= in_data;
                    skid_ctrl <= in_ctrl;
                    skid_q    <= 1'b1;
                end
            end
        end else begin : g_single
            assign in_ready   = ~rst & (~main_valid | out_ready);
            assign skid_valid = 1'b0;

            always_ff @(posedge clk) begin
                if (rst) begin
                    main_valid <= 1'b0;
                    main_data  <= '0;
                    main_ctrl  <= '0;
                end else if (flush) begin
                    main_valid <= 1'b0;
                end else if (accept) begin
                    main_data  <= in_data;
                    main_ctrl  <= in_ctrl;
                    main_valid <= 1'b1;
                end else if (emit) begin
                    main_valid <= 1'b0;
                end
            end
        end
    endgenerate

    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign out_ctrl  = main_valid ? main_ctrl : '0;
    assign count     = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one SKID=1 and one SKID=0 instance share the same
// input stimulus. Each has a queue model of held entries; a compare process
// checks every output against its model each cycle, and directed literal
// checks pin the model at the interesting points.
module tb_pipe_stage_reg;
    localparam int DATA_W = 133;
    localparam int CTRL_W = 8;
    localparam int ENT_W  = DATA_W + CTRL_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic [CTRL_W-1:0] in_ctrl = '0;
    logic              out_ready = 1'b0;

    logic              in_ready1, out_valid1, in_ready0, out_valid0;
    logic [DATA_W-1:0] out_data1, out_data0;
    logic [CTRL_W-1:0] out_ctrl1, out_ctrl0;
    logic [1:0]        count1, count0;

    pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID(1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid1), .out_ready(out_ready),
        .out_data(out_data1), .out_ctrl(out_ctrl1), .count(count1)
    );

    pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID(0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_data(out_data0), .out_ctrl(out_ctrl0), .count(count0)
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // Held entries as FIFO queues; capacity 2 (SKID=1) or 1 (SKID=0).
    logic [ENT_W-1:0]  exp_q1[$];
    logic [ENT_W-1:0]  exp_q0[$];
    logic [DATA_W-1:0] shown1 = '0;
    logic [DATA_W-1:0] shown0 = '0;
    bit                live = 0;

    function automatic bit rdy1();
        return !rst && (exp_q1.size() < 2);
    endfunction

    function automatic bit rdy0();
        return !rst && (exp_q0.size() == 0 || out_ready);
    endfunction

    always @(posedge clk) begin
        bit acc1, emt1, acc0, emt0;
        acc1 = in_valid && rdy1();
        emt1 = (exp_q1.size() > 0) && out_ready;
        acc0 = in_valid && rdy0();
        emt0 = (exp_q0.size() > 0) && out_ready;
        if (rst) begin
            exp_q1.delete(); exp_q0.delete();
            shown1 = '0; shown0 = '0;
            live = 1;
        end else if (flush) begin
            exp_q1.delete(); exp_q0.delete();
        end else begin
            if (emt1) void'(exp_q1.pop_front());
            if (acc1) exp_q1.push_back({in_data, in_ctrl});
            if (emt0) void'(exp_q0.pop_front());
            if (acc0) exp_q0.push_back({in_data, in_ctrl});
        end
        // Presented data is the head entry; it lingers after the queue drains.
        if (exp_q1.size() > 0) shown1 = exp_q1[0][ENT_W-1:CTRL_W];
        if (exp_q0.size() > 0) shown0 = exp_q0[0][ENT_W-1:CTRL_W];
    end

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (live) begin
                check("out_valid1", 256'(out_valid1), 256'(exp_q1.size() > 0));
                check("out_data1",  256'(out_data1),  256'(shown1));
                check("out_ctrl1",  256'(out_ctrl1),  exp_q1.size() > 0 ? 256'(exp_q1[0][CTRL_W-1:0]) : 256'(0));
                check("count1",     256'(count1),     256'(exp_q1.size()));
                check("in_ready1",  256'(in_ready1),  256'(rdy1()));
                check("out_valid0", 256'(out_valid0), 256'(exp_q0.size() > 0));
                check("out_data0",  256'(out_data0),  256'(shown0));
                check("out_ctrl0",  256'(out_ctrl0),  exp_q0.size() > 0 ? 256'(exp_q0[0][CTRL_W-1:0]) : 256'(0));
                check("count0",     256'(count0),     256'(exp_q0.size()));
                check("in_ready0",  256'(in_ready0),  256'(rdy0()));
            end
        end
    end

    // ---------------- driver ----------------
    // Inputs change on the falling edge; literal checks follow 3 time units
    // later, seeing the state after all previous rising edges.
    task automatic step(input bit r, input bit f, input bit iv,
                        input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                        input bit ordy);
        @(negedge clk);
        rst = r; flush = f; in_valid = iv; in_data = d; in_ctrl = c; out_ready = ordy;
        #3;
    endtask

    task automatic drain();
        for (int k = 0; k < 3; k++) step(0, 0, 0, '0, '0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        // Reset with garbage presented upstream.
        for (int k = 0; k < 3; k++) step(1, 0, 1, DATA_W'(5), 8'hFF, 0);
        check("rst out_valid", 256'(out_valid1), 256'(0));
        check("rst out_ctrl",  256'(out_ctrl1),  256'(0));
        check("rst count",     256'(count1),     256'(0));
        check("rst in_ready",  256'(in_ready1),  256'(0));
        step(0, 0, 0, '0, '0, 0);
        check("rst release in_ready", 256'(in_ready1), 256'(1));

        // Streaming 1..10.
        for (int i = 1; i <= 10; i++) begin
            step(0, 0, 1, DATA_W'(i), CTRL_W'(i), 1);
            if (i > 1) begin
                check("stream out_data", 256'(out_data1), 256'(i - 1));
                check("stream count",    256'(count1),    256'(1));
                check("stream in_ready", 256'(in_ready1), 256'(1));
            end
        end
        step(0, 0, 0, '0, '0, 1);
        check("stream last", 256'(out_data1), 256'(10));
        step(0, 0, 0, '0, '0, 1);
        check("stream drained valid", 256'(out_valid1), 256'(0));
        check("stream drained data",  256'(out_data1),  256'(10));

        // Back-pressure into skid.
        step(0, 0, 1, DATA_W'('h11), 8'h01, 0);
        step(0, 0, 1, DATA_W'('h22), 8'h02, 0);
        step(0, 0, 0, '0, '0, 0);
        check("bp count",    256'(count1),    256'(2));
        check("bp in_ready", 256'(in_ready1), 256'(0));
        check("bp head",     256'(out_data1), 256'('h11));
        step(0, 0, 0, '0, '0, 1);
        check("bp first", 256'(out_data1), 256'('h11));
        step(0, 0, 0, '0, '0, 1);
        check("bp second",       256'(out_data1), 256'('h22));
        check("bp second ctrl",  256'(out_ctrl1), 256'('h02));
        check("bp ready back",   256'(in_ready1), 256'(1));
        step(0, 0, 0, '0, '0, 1);
        check("bp empty valid", 256'(out_valid1), 256'(0));
        check("bp empty ctrl",  256'(out_ctrl1),  256'(0));
        check("bp held data",   256'(out_data1),  256'('h22));

        // Flush with two held entries and a simultaneous accept.
        step(0, 0, 1, DATA_W'('h44), 8'h04, 0);
        step(0, 0, 1, DATA_W'('h55), 8'h05, 0);
        step(0, 1, 1, DATA_W'('h33), 8'h03, 0);
        check("pre-flush count", 256'(count1), 256'(2));
        step(0, 0, 0, '0, '0, 1);
        check("flush valid", 256'(out_valid1), 256'(0));
        check("flush count", 256'(count1),     256'(0));
        check("flush data kept", 256'(out_data1), 256'('h44));
        drain();

        // Bubble mask.
        step(0, 0, 1, DATA_W'('h66), 8'h5A, 0);
        step(0, 0, 0, '0, '0, 1);
        check("bubble ctrl live", 256'(out_ctrl1), 256'('h5A));
        step(0, 0, 0, '0, '0, 1);
        check("bubble ctrl masked", 256'(out_ctrl1),  256'(0));
        check("bubble valid",       256'(out_valid1), 256'(0));
        check("bubble data held",   256'(out_data1),  256'('h66));

        // Single-entry variant: combinational ready and replace-on-emit.
        step(0, 0, 1, DATA_W'('h77), 8'h07, 0);
        step(0, 0, 0, '0, '0, 0);
        check("s0 in_ready low", 256'(in_ready0), 256'(0));
        check("s0 count",        256'(count0),    256'(1));
        step(0, 0, 1, DATA_W'('h88), 8'h08, 1);
        check("s0 in_ready comb", 256'(in_ready0), 256'(1));
        step(0, 0, 0, '0, '0, 0);
        check("s0 replaced", 256'(out_data0), 256'('h88));
        check("s0 count kept", 256'(count0),  256'(1));
        drain();

        // Mixed valid/ready pattern, model-checked every cycle.
        for (int i = 0; i < 24; i++)
            step(0, 0, (i % 3) != 0, DATA_W'(256 + i), CTRL_W'(i + 1), (i % 4) != 1);

        // Reset mid-stream.
        step(0, 0, 1, DATA_W'('h99), 8'h09, 0);
        step(0, 0, 1, DATA_W'('hAA), 8'h0A, 0);
        step(1, 0, 1, DATA_W'('hBB), 8'h0B, 0);
        step(0, 0, 0, '0, '0, 0);
        check("mid rst count", 256'(count1),    256'(0));
        check("mid rst data",  256'(out_data1), 256'(0));
        check("mid rst valid", 256'(out_valid1), 256'(0));
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised elastic pipeline register for the CPU stage boundaries (ID/EX, EX/MEM, MEM/WB); supersedes the fixed free-running stage registers.
- Adds valid/ready handshake, a 2-entry skid buffer for registered back-pressure, synchronous flush, and bubble masking of control bits.
- Payload is split into control bits (zeroed on bubbles) and data bits (held).

Parameters:
- DATA_W, 133, width of data payload (dest, reg2, val2, val1, pc packed by the instantiating stage).
- CTRL_W, 8, width of control payload (br_taken, exe_cmd, mem_r_en, mem_w_en, wb_en, spare); masked to 0 when no valid entry is presented.
- SKID, 1, 1 = two entries with registered in_ready; 0 = single entry with combinational in_ready.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  block can accept an entry this cycle.
- in_data  in  DATA_W  upstream data payload.
- in_ctrl  in  CTRL_W  upstream control payload.
- out_valid  out  1  entry presented downstream.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  presented data payload.
- out_ctrl  out  CTRL_W  presented control payload; all 0 when out_valid=0.
- count  out  2  number of held entries (0..2).

Behaviour:
- Reset: synchronous; one rst-high edge clears main_valid, skid_valid, main/skid data and ctrl, so out_valid=0, out_data=0, out_ctrl=0, count=0. in_ready is forced 0 while rst=1 and reads 1 on the first cycle after rst falls. Reset mid-stream discards all entries.
- Handshakes: accept = in_valid & in_ready. Emit = out_valid & out_ready. Each completes on the rising edge where it holds.
- Outputs: out_valid = main_valid. out_data = main_data. out_ctrl = main_valid ? main_ctrl : 0.
- in_ready with SKID=1: ~skid_valid, driven purely from registers with no combinational path from out_ready.
- in_ready with SKID=0: ~main_valid | out_ready.
- SKID=1 transitions (flush=0):
  - main empty, accept: entry into main.
  - main full, emit and accept: entry into main, skid stays empty.
  - main full, no emit, accept: entry into skid. in_ready drops the next cycle.
  - main and skid full, emit: skid moves into main, skid empties, in_ready rises the next cycle.
  - main full, emit, no accept, skid empty: main empties.
- Ordering: strict FIFO. The main entry always precedes the skid entry.
- Data hold: main_data and skid_data hold their values when they are not overwritten. out_data after an entry drains keeps its last value; only ctrl is masked.
- Flush:
  - Priority over everything except rst.
  - On an edge with flush=1, both valid bits clear and count=0.
  - A handshake completing in that same cycle is discarded; upstream is flushed in the same cycle by the hazard unit.
  - Data registers are not cleared.
- Count: main_valid + skid_valid. With SKID=0, skid_valid is constant 0 and count is at most 1.
- Throughput and latency: 1 entry per cycle sustained with out_ready held at 1. Latency is 1 cycle from accept to out_valid.
- The block never drops or duplicates an entry except on flush or rst.

Test Plan:
- Reset: in_valid=1, in_ctrl=8'hFF during rst -> out_valid=0, out_ctrl=0, count=0, in_ready=0 while rst=1; in_ready=1 on the first cycle after rst falls.
- Streaming: out_ready=1, in_valid=1, in_data 1..10 on consecutive cycles -> out_data 1..10 one cycle later, in_ready held at 1, count=1 throughout.
- Back-pressure (SKID=1):
  - Accept A=0x11, then B=0x22 with out_ready=0 -> count=2, in_ready=0.
  - Raise out_ready -> out_data 0x11 then 0x22 in order, then out_valid=0 with out_ctrl=0 and out_data held at 0x22.
- Flush: with two entries held, flush=1 together with in_valid=1 carrying 0x33 -> next cycle out_valid=0, count=0, and 0x33 is never presented.
- Bubble mask: accept in_ctrl=8'h5A, then emit with no new input -> after drain out_ctrl=0, out_valid=0, out_data unchanged.
- SKID=0 variant: out_ready=0 with one entry held -> in_ready=0 combinationally; asserting out_ready makes in_ready=1 in the same cycle and a simultaneous accept replaces main with count staying 1.
